// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants, counter widths and the timing-recovery FSM state type.
package vga_timing_pkg;

    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Sync sample register with 1->0 edge detect against the previous strobe's sample.
module vga_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_stb,
    input  logic i_sync,
    output logic o_fall
);

    logic prev_q;

    // History resets high so a sync already low after reset reads as an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q <= 1'b1;
        end else if (i_stb) begin
            prev_q <= i_sync;
        end
    end

    assign o_fall = i_stb & prev_q & ~i_sync;

endmodule

// File: rtl/vga_timing_recover.sv
// Recovers pixel position, data enable and lock status from a VGA sync/colour stream.
// Optional frame checksum accumulator is built only when VGA_RX_CHECKSUM_EN is defined.
module vga_timing_recover
    import vga_timing_pkg::*;
#(
    parameter int HSYNC = H_SYNC,
    parameter int HBP   = H_BACK,
    parameter int HACT  = H_ACTIVE,
    parameter int HTOT  = H_TOTAL,
    parameter int VSYNC = V_SYNC,
    parameter int VBP   = V_BACK,
    parameter int VACT  = V_ACTIVE,
    parameter int VTOT  = V_TOTAL
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_stb,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic [3:0]         i_r,
    input  logic [3:0]         i_g,
    input  logic [3:0]         i_b,
    output logic [X_W-1:0]     o_x,
    output logic [Y_W-1:0]     o_y,
    output logic               o_de,
    output logic [11:0]        o_rgb,
    output logic               o_locked,
    output logic               o_frame_start,
    output logic               o_err,
    output logic [15:0]        o_checksum,
    output state_t             o_state
);

    localparam logic [HCNT_W-1:0] H_A0   = HCNT_W'(HSYNC + HBP);
    localparam logic [HCNT_W-1:0] H_A1   = HCNT_W'(HSYNC + HBP + HACT - 1);
    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(HTOT - 1);
    localparam logic [VCNT_W-1:0] V_A0   = VCNT_W'(VSYNC + VBP);
    localparam logic [VCNT_W-1:0] V_A1   = VCNT_W'(VSYNC + VBP + VACT - 1);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(VTOT - 1);

    logic [HCNT_W-1:0] hcnt_q, h_nx;
    logic [VCNT_W-1:0] vcnt_q, v_nx;
    state_t            state_q, state_nx;
    logic              bad_q, bad_nx;
    logic              hs_fall, vs_fall;
    logic              line_fail, frame_fail, err_nx;
    logic              in_area, de_nx, fs_nx;
    logic [11:0]       rgb_in;

    vga_sync_edge u_hs_edge (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_stb  (i_pix_stb),
        .i_sync (i_hs),
        .o_fall (hs_fall)
    );

    vga_sync_edge u_vs_edge (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_stb  (i_pix_stb),
        .i_sync (i_vs),
        .o_fall (vs_fall)
    );

    assign rgb_in = {i_r, i_g, i_b};

    // i_pix_stb is the sole qualifier: with it low, inputs are ignored and all state holds.
    always_comb begin
        h_nx = hcnt_q;
        v_nx = vcnt_q;
        if (i_pix_stb) begin
            if (hs_fall) begin
                h_nx = '0;
            end else if (hcnt_q != '1) begin
                h_nx = hcnt_q + 1'b1;
            end
            if (vs_fall) begin
                v_nx = '0;
            end else if (hs_fall && vcnt_q != '1) begin
                v_nx = vcnt_q + 1'b1;
            end
        end
    end

    assign line_fail  = hs_fall && (hcnt_q != H_LAST);
    assign frame_fail = vs_fall && (vcnt_q != V_LAST);

    always_comb begin
        state_nx = state_q;
        bad_nx   = bad_q;
        err_nx   = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_nx = MEASURE;
                    bad_nx   = 1'b0;
                end
            end
            MEASURE: begin
                // The frame boundary also closes the last line, so its line check counts here.
                if (vs_fall) begin
                    if (!frame_fail && !line_fail && !bad_q) begin
                        state_nx = LOCKED;
                    end
                    bad_nx = 1'b0;
                end else if (line_fail) begin
                    bad_nx = 1'b1;
                end
            end
            LOCKED: begin
                if (line_fail || frame_fail) begin
                    state_nx = SEARCH;
                    err_nx   = 1'b1;
                end
            end
            default: begin
                state_nx = SEARCH;
            end
        endcase
    end

    assign in_area = (h_nx >= H_A0) && (h_nx <= H_A1) && (v_nx >= V_A0) && (v_nx <= V_A1);
    assign de_nx   = in_area && (state_nx == LOCKED);
    assign fs_nx   = i_pix_stb && (state_nx == LOCKED) && (h_nx == H_A0) && (v_nx == V_A0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            state_q       <= SEARCH;
            bad_q         <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_de          <= 1'b0;
            o_rgb         <= '0;
            o_frame_start <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            hcnt_q        <= h_nx;
            vcnt_q        <= v_nx;
            state_q       <= state_nx;
            bad_q         <= bad_nx;
            o_frame_start <= fs_nx;
            o_err         <= err_nx;
            if (i_pix_stb) begin
                o_de  <= de_nx;
                o_rgb <= de_nx ? rgb_in : 12'h000;
                if (in_area) begin
                    o_x <= X_W'(h_nx - H_A0);
                    o_y <= Y_W'(v_nx - V_A0);
                end
            end
        end
    end

    assign o_locked = (state_q == LOCKED);
    assign o_state  = state_q;

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] acc_q;
    logic [15:0] sum_q;

    // Frame start latches the previous frame's total and seeds the new one with its own pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            sum_q <= '0;
        end else if (i_pix_stb) begin
            if (state_nx != LOCKED) begin
                acc_q <= '0;
            end else if (fs_nx) begin
                sum_q <= acc_q;
                acc_q <= {4'h0, rgb_in};
            end else if (de_nx) begin
                acc_q <= acc_q + {4'h0, rgb_in};
            end
        end
    end

    assign o_checksum = sum_q;
`else
    assign o_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_recover.sv
// Directed bench for vga_timing_recover using a reduced raster so whole frames stay short.
module tb_vga_timing_recover;
    import vga_timing_pkg::*;

    localparam int HS  = 4;
    localparam int HB  = 3;
    localparam int HA  = 8;
    localparam int HT  = 17;
    localparam int VS  = 2;
    localparam int VB  = 2;
    localparam int VA  = 4;
    localparam int VT  = 9;
    localparam int HA0 = HS + HB;
    localparam int VA0 = VS + VB;
    localparam int W   = 51;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb;
    logic        hs;
    logic        vs;
    logic [3:0]  r, g, b;
    logic [9:0]  o_x;
    logic [8:0]  o_y;
    logic        o_de;
    logic [11:0] o_rgb;
    logic        o_locked;
    logic        o_frame_start;
    logic        o_err;
    logic [15:0] o_checksum;
    state_t      dbg_state;

    vga_timing_recover #(
        .HSYNC(HS), .HBP(HB), .HACT(HA), .HTOT(HT),
        .VSYNC(VS), .VBP(VB), .VACT(VA), .VTOT(VT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pix_stb    (stb),
        .i_hs         (hs),
        .i_vs         (vs),
        .i_r          (r),
        .i_g          (g),
        .i_b          (b),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_de         (o_de),
        .o_rgb        (o_rgb),
        .o_locked     (o_locked),
        .o_frame_start(o_frame_start),
        .o_err        (o_err),
        .o_checksum   (o_checksum),
        .o_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           exp_fs  = 0;
    int           exp_err = 0;
    int           act_fs  = 0;
    int           act_err = 0;
    int           ex_x;
    int           ex_y;
    logic [15:0]  acc;
    logic [15:0]  ck;

    function automatic logic [W-1:0] out_vec();
        return {o_locked, o_de, o_x, o_y, o_rgb, o_frame_start, o_err, o_checksum};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ex_x = 0;
        ex_y = 0;
        acc  = 16'h0;
        ck   = 16'h0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic h, input logic v, input logic [11:0] rgb, input logic [W-1:0] e);
        repeat (3) @(negedge clk);
        exp_q.push_back(e);
        hs = h;
        vs = v;
        {r, g, b} = rgb;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
    endtask

    // lk: lock status from the frame's first strobe; err_line: line whose first strobe loses lock.
    task automatic send_frame(input int nlines, input int short_line, input bit lk,
                              input int err_line, input bit pat, input int tail);
        bit          lk_now;
        int          total;
        int          len;
        bit          in_area, de, fs, er;
        logic [11:0] rgb;
        logic [15:0] ck_e;
        lk_now = lk;
        total  = nlines + ((tail > 0) ? 1 : 0);
        for (int l = 0; l < total; l++) begin
            len = (l == short_line) ? HT - 1 : HT;
            if (l == nlines) len = tail;
            for (int h = 0; h < len; h++) begin
                er = (l == err_line) && (h == 0);
                if (er) begin
                    lk_now = 1'b0;
                    exp_err++;
                end
                if (pat) rgb = (l == VA0 + 1 && h == HA0 + 3) ? 12'hABC : 12'(l * 37 + h * 5);
                else     rgb = 12'h001;
                in_area = (h >= HA0) && (h < HA0 + HA) && (l >= VA0) && (l < VA0 + VA);
                de      = lk_now && in_area;
                fs      = lk_now && (h == HA0) && (l == VA0);
                if (in_area) begin
                    ex_x = h - HA0;
                    ex_y = l - VA0;
                end
                if (!lk_now)  acc = 16'h0;
                else if (fs) begin
                    ck  = acc;
                    acc = {4'h0, rgb};
                end else if (de) acc = acc + {4'h0, rgb};
                if (fs) exp_fs++;
`ifdef VGA_RX_CHECKSUM_EN
                ck_e = ck;
`else
                ck_e = 16'h0;
`endif
                drive(h >= HS, l >= VS, rgb,
                      {lk_now, de, 10'(ex_x), 9'(ex_y), de ? rgb : 12'h000, fs, er, ck_e});
            end
        end
    endtask

    // ---------------- monitors ----------------
    always @(posedge clk) begin
        if (stb && rst_n) begin
            #1;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                check("strobe_outputs", 64'(out_vec()), 64'(exp_q.pop_front()));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (o_frame_start) act_fs++;
        if (o_err)         act_err++;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        stb   = 1'b0;
        hs    = 1'b1;
        vs    = 1'b1;
        {r, g, b} = 12'h000;
        model_reset();
        #12;
        check("reset_outputs", 64'(out_vec()), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(SEARCH));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Two clean frames: lock at the second vsync edge, then constant colour for checksum.
        send_frame(VT, -1, 1'b0, -1, 1'b0, 0);
        check("measure_after_first_frame", 64'({o_locked, dbg_state}), 64'({1'b0, MEASURE}));
        send_frame(VT, -1, 1'b1, -1, 1'b0, 0);
        send_frame(VT, -1, 1'b1, -1, 1'b0, 0);
`ifdef VGA_RX_CHECKSUM_EN
        check("checksum_second_locked_frame", 64'(o_checksum), 64'h0020);
`else
        check("checksum_disabled", 64'(o_checksum), 64'h0000);
`endif
        // Pattern frame carrying 0xABC at x=3,y=1.
        send_frame(VT, -1, 1'b1, -1, 1'b1, 0);
        // Short line 3 breaks lock at line 4; relock two frames later.
        send_frame(VT, 3, 1'b1, 4, 1'b1, 0);
        check("unlocked_after_short_line", 64'({o_locked, dbg_state}), 64'({1'b0, SEARCH}));
        send_frame(VT, -1, 1'b0, -1, 1'b1, 0);
        send_frame(VT, -1, 1'b1, -1, 1'b1, 0);

        // Partial frame, then asynchronous reset in the middle of an active line.
        send_frame(5, -1, 1'b1, -1, 1'b1, 10);
        check("pre_reset_de", 64'({o_locked, o_de}), 64'b11);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'(out_vec()), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Short frame while measuring keeps MEASURE without an error, then locks.
        send_frame(VT - 1, -1, 1'b0, -1, 1'b1, 0);
        send_frame(VT, -1, 1'b0, -1, 1'b1, 0);
        check("measure_after_short_frame", 64'({o_locked, dbg_state}), 64'({1'b0, MEASURE}));
        send_frame(VT, -1, 1'b1, -1, 1'b1, 0);
        check("relocked", 64'(o_locked), 64'd1);

        repeat (8) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("frame_start_pulses", 64'(act_fs), 64'(exp_fs));
        check("err_pulses", 64'(act_err), 64'(exp_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
